// File: rtl/mutex_lock_agent.sv
// mutex_lock_agent
// Avalon-MM master that acquires the system hardware mutex for a local RTL
// client. It writes {OWNER_ID, LOCK_VALUE}, reads the register back, and
// owns the mutex only when the full 32-bit readback matches. Failed attempts
// are retried after a fixed backoff. The mutex is released by writing
// {OWNER_ID, 16'h0000} when the request drops.
// Optional build macro: MUTEX_TIMEOUT_EN. When it is defined, the agent gives
// up after MAX_RETRIES failed attempts. It then pulses lock_fail and parks in
// FAIL until the request drops. When it is undefined, retries are unlimited.
module mutex_lock_agent #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lock_req,
  output logic        lock_grant,
  output logic        busy,
  output logic [7:0]  retry_count,
  output logic        lock_fail,
  output logic        m_address,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid
);

  localparam logic [31:0] LOCK_WORD    = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] REL_WORD     = {OWNER_ID, 16'h0000};
  localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_LOCK  = 3'd1,
    ST_RD_CHECK = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_BACKOFF  = 3'd4,
    ST_HELD     = 3'd5,
    ST_WR_REL   = 3'd6
`ifdef MUTEX_TIMEOUT_EN
    , ST_FAIL   = 3'd7
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] backoff_q, backoff_d;

  // Output registers. Their next values are decoded from the next state,
  // so every output is a flop that lines up with the state it belongs to.
  logic        grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        cs_q;
  logic [31:0] wdata_q, wdata_d;

`ifdef MUTEX_TIMEOUT_EN
  logic        fail_q, fail_d;
`else
  logic        unused_retry_limit;
  assign unused_retry_limit = ^RETRY_LIMIT;
`endif

  // Next-state, retry and backoff bookkeeping for the acquire/release protocol.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    backoff_d = backoff_q;
`ifdef MUTEX_TIMEOUT_EN
    fail_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lock_req) begin
          retry_d = 8'd0;
          state_d = ST_WR_LOCK;
        end
      end
      // The command is held until the fabric stops stalling. A request drop
      // never truncates a transfer.
      ST_WR_LOCK: begin
        if (!m_waitrequest) state_d = ST_RD_CHECK;
      end
      ST_RD_CHECK: begin
        if (!m_waitrequest) state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (m_readdatavalid) begin
          if (m_readdata == LOCK_WORD) begin
            // We own it. If the client lost interest meanwhile, give it back.
            state_d = lock_req ? ST_HELD : ST_WR_REL;
          end else begin
            retry_d   = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            backoff_d = BACKOFF_LOAD;
`ifdef MUTEX_TIMEOUT_EN
            if (retry_d == RETRY_LIMIT) begin
              fail_d  = 1'b1;
              state_d = ST_FAIL;
            end else if (!lock_req) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BACKOFF;
            end
`else
            state_d = lock_req ? ST_BACKOFF : ST_IDLE;
`endif
          end
        end
      end
      ST_BACKOFF: begin
        if (!lock_req) begin
          state_d = ST_IDLE;
        end else if (backoff_q == 16'd0) begin
          state_d = ST_WR_LOCK;
        end else begin
          backoff_d = backoff_q - 16'd1;
        end
      end
      ST_HELD: begin
        if (!lock_req) state_d = ST_WR_REL;
      end
      ST_WR_REL: begin
        if (!m_waitrequest) state_d = ST_IDLE;
      end
`ifdef MUTEX_TIMEOUT_EN
      ST_FAIL: begin
        if (!lock_req) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode the registered outputs from the state being entered.
  always_comb begin
    grant_d = 1'b0;
    busy_d  = 1'b1;
    read_d  = 1'b0;
    write_d = 1'b0;
    wdata_d = 32'h0;
    case (state_d)
      ST_IDLE: busy_d = 1'b0;
      ST_HELD: begin
        busy_d  = 1'b0;
        grant_d = 1'b1;
      end
      ST_WR_LOCK: begin
        write_d = 1'b1;
        wdata_d = LOCK_WORD;
      end
      ST_RD_CHECK: read_d = 1'b1;
      ST_WR_REL: begin
        write_d = 1'b1;
        wdata_d = REL_WORD;
      end
      default: ;
    endcase
  end

  // State, counters and output flops. A reset aborts any transfer and does
  // not release a mutex that is currently held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= 8'd0;
      backoff_q <= 16'd0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      cs_q      <= 1'b0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      backoff_q <= backoff_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      read_q    <= read_d;
      write_q   <= write_d;
      cs_q      <= read_d | write_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef MUTEX_TIMEOUT_EN
  // The give-up pulse is registered like every other output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fail_q <= 1'b0;
    else          fail_q <= fail_d;
  end
  assign lock_fail = fail_q;
`else
  assign lock_fail = 1'b0;
`endif

  // Only the mutex register is ever addressed. The reset register is unused.
  assign m_address    = 1'b0;
  assign lock_grant   = grant_q;
  assign busy         = busy_q;
  assign retry_count  = retry_q;
  assign m_chipselect = cs_q;
  assign m_read       = read_q;
  assign m_write      = write_q;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_mutex_lock_agent.sv
// Testbench for mutex_lock_agent (default parameters, default build).
// A behavioural mutex slave answers the agent's bus traffic. The slave
// applies random stalls and random read latency. Each task checks one
// scenario against values the bench works out on its own.
`timescale 1ns/1ps
module tb_mutex_lock_agent;

  localparam logic [31:0] LOCK_WORD = 32'h0001_0001;
  localparam logic [31:0] REL_WORD  = 32'h0001_0000;
  localparam int          BACKOFF   = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lock_req = 1'b0;
  logic        lock_grant, busy, lock_fail;
  logic [7:0]  retry_count;
  logic        m_address, m_chipselect, m_read, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'h0;
  logic        m_waitrequest = 1'b0;
  logic        m_readdatavalid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mutex_lock_agent dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .lock_req        (lock_req),
    .lock_grant      (lock_grant),
    .busy            (busy),
    .retry_count     (retry_count),
    .lock_fail       (lock_fail),
    .m_address       (m_address),
    .m_chipselect    (m_chipselect),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural mutex slave ----------------
  logic [31:0] mutex_val = 32'h0;
  int stall_min = 0, stall_max = 0, lat_min = 1, lat_max = 1;
  int proto_err = 0;
  int n_rd = 0;
  logic [31:0] wr_log_data[$];
  int          wr_log_cyc[$];
  logic [31:0] rd_log[$];

  logic        prev_cmd = 1'b0, prev_wait = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_wd = 32'h0;
  logic        stall_active = 1'b0;
  int          stall_left = 0;
  logic        rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] rd_hold = 32'h0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b0;
      m_readdata      = 32'h0;
      stall_active    = 1'b0;
      rd_pend         = 1'b0;
      prev_cmd        = 1'b0;
      prev_wait       = 1'b0;
      prev_rd         = 1'b0;
      prev_wr         = 1'b0;
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata      = $urandom;
      // A transfer was accepted at the last rising edge.
      if (prev_cmd && !prev_wait) begin
        if (prev_wr) begin
          wr_log_data.push_back(prev_wd);
          wr_log_cyc.push_back(cyc);
          if (prev_wd != LOCK_WORD && prev_wd != REL_WORD) proto_err++;
          // Mutex rule: a write lands if the mutex is free or the owner matches.
          if (mutex_val[15:0] == 16'h0 || mutex_val[31:16] == prev_wd[31:16])
            mutex_val = prev_wd;
        end
        if (prev_rd) begin
          if (rd_pend) proto_err++;
          n_rd++;
          rd_pend = 1'b1;
          rd_hold = mutex_val;
          rd_cnt  = $urandom_range(lat_max, lat_min);
        end
      end
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_pend         = 1'b0;
          m_readdatavalid = 1'b1;
          m_readdata      = rd_hold;
          rd_log.push_back(rd_hold);
        end
      end
      if (m_chipselect !== (m_read | m_write)) proto_err++;
      if (m_read && m_write) proto_err++;
      if ((m_read || m_write) && m_address !== 1'b0) proto_err++;
      if (prev_cmd && prev_wait &&
          (m_read !== prev_rd || m_write !== prev_wr || m_writedata !== prev_wd))
        proto_err++;
      if (m_read || m_write) begin
        if (!stall_active) begin
          stall_active = 1'b1;
          stall_left   = $urandom_range(stall_max, stall_min);
        end
        m_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        else stall_active = 1'b0;
      end else begin
        m_waitrequest = 1'b0;
        stall_active  = 1'b0;
      end
      prev_cmd  = m_read || m_write;
      prev_wait = m_waitrequest;
      prev_rd   = m_read;
      prev_wr   = m_write;
      prev_wd   = m_writedata;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n  = 1'b0;
    lock_req = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({lock_grant, busy, lock_fail, m_address, m_chipselect, m_read, m_write} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {lock_grant, busy, lock_fail, m_address, m_chipselect, m_read, m_write});
    else n_pass++;
    n_checks++;
    if ({retry_count, m_writedata} !== 40'h0)
      $display("FAIL reset_data: got retry=%0d wdata=%h expected 0/0", retry_count, m_writedata);
    else n_pass++;
    lock_req = 1'b0;
    reset_n  = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({busy, m_write, m_read} !== 3'b0)
      $display("FAIL idle_after_reset: got %b expected 000", {busy, m_write, m_read});
    else n_pass++;
  endtask

  task automatic test_free_acquire();
    int w0, r0, got;
    mutex_val = 32'h0;
    w0 = wr_log_data.size();
    r0 = rd_log.size();
    got = -1;
    lock_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (lock_grant && got < 0) got = i;
    end
    n_checks++;
    if (got !== 4) $display("FAIL free_grant_latency: got %0d expected 4", got);
    else n_pass++;
    n_checks++;
    if (wr_log_data.size() != w0 + 1 || wr_log_data[w0] !== LOCK_WORD)
      $display("FAIL free_lock_write: got %0d writes expected 1 of %h", wr_log_data.size() - w0, LOCK_WORD);
    else n_pass++;
    n_checks++;
    if (rd_log.size() != r0 + 1 || rd_log[r0] !== LOCK_WORD)
      $display("FAIL free_readback: got %0d reads expected 1 returning %h", rd_log.size() - r0, LOCK_WORD);
    else n_pass++;
    n_checks++;
    if ({busy, retry_count} !== 9'h0)
      $display("FAIL free_held_status: got busy=%b retry=%0d expected 0/0", busy, retry_count);
    else n_pass++;
    lock_req = 1'b0;
    step();
    n_checks++;
    if ({lock_grant, m_write, m_writedata} !== {1'b0, 1'b1, REL_WORD})
      $display("FAIL release_same_cycle: got grant=%b write=%b wdata=%h expected 0/1/%h",
               lock_grant, m_write, m_writedata, REL_WORD);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (mutex_val !== REL_WORD || busy !== 1'b0)
      $display("FAIL release_done: got mutex=%h busy=%b expected %h/0", mutex_val, busy, REL_WORD);
    else n_pass++;
  endtask

  task automatic test_contended();
    int w0, r0;
    logic ok;
    mutex_val = 32'h0002_0007;
    w0 = wr_log_data.size();
    r0 = rd_log.size();
    lock_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (wr_log_data.size() >= w0 + 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL contended_attempts: got %0d writes expected 3", wr_log_data.size() - w0);
    else n_pass++;
    if (ok) begin
      n_checks++;
      if (retry_count !== 8'd2) $display("FAIL contended_retry: got %0d expected 2", retry_count);
      else n_pass++;
      // One cycle each for write, read and read-wait, then BACKOFF idle cycles.
      n_checks++;
      if (wr_log_cyc[w0 + 1] - wr_log_cyc[w0] != BACKOFF + 3 ||
          wr_log_cyc[w0 + 2] - wr_log_cyc[w0 + 1] != BACKOFF + 3)
        $display("FAIL contended_gap: got %0d,%0d expected %0d", wr_log_cyc[w0 + 1] - wr_log_cyc[w0],
                 wr_log_cyc[w0 + 2] - wr_log_cyc[w0 + 1], BACKOFF + 3);
      else n_pass++;
      n_checks++;
      if (rd_log[r0] !== 32'h0002_0007)
        $display("FAIL contended_readback: got %h expected 00020007", rd_log[r0]);
      else n_pass++;
    end
    // Software frees the mutex. The in-flight readback still fails, and the
    // attempt after it wins.
    mutex_val = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (lock_grant) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || retry_count !== 8'd3 || mutex_val !== LOCK_WORD)
      $display("FAIL contended_grant: got grant=%b retry=%0d mutex=%h expected 1/3/%h",
               ok, retry_count, mutex_val, LOCK_WORD);
    else n_pass++;
    lock_req = 1'b0;
    repeat (5) step();
    n_checks++;
    if ({busy, lock_grant} !== 2'b00 || mutex_val !== REL_WORD)
      $display("FAIL contended_release: got busy=%b grant=%b mutex=%h expected 0/0/%h",
               busy, lock_grant, mutex_val, REL_WORD);
    else n_pass++;
  endtask

  task automatic test_waitrequest();
    int r0, p0, got, n_wr_cyc, n_rd_cyc;
    mutex_val = 32'h0;
    stall_min = 5;
    stall_max = 5;
    lat_min   = 3;
    lat_max   = 3;
    r0 = n_rd;
    p0 = proto_err;
    got = -1;
    n_wr_cyc = 0;
    n_rd_cyc = 0;
    lock_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (m_write && m_writedata === LOCK_WORD) n_wr_cyc++;
      if (m_read) n_rd_cyc++;
      if (lock_grant && got < 0) got = i;
    end
    // 1 (idle) + 6 (write, 5 stalled) + 6 (read, 5 stalled) + 3 (latency).
    n_checks++;
    if (got !== 16) $display("FAIL stall_grant_latency: got %0d expected 16", got);
    else n_pass++;
    n_checks++;
    if (n_wr_cyc != 6 || n_rd_cyc != 6)
      $display("FAIL stall_hold_cycles: got write=%0d read=%0d expected 6/6", n_wr_cyc, n_rd_cyc);
    else n_pass++;
    n_checks++;
    if (n_rd - r0 != 1 || proto_err != p0)
      $display("FAIL stall_protocol: got reads=%0d errors=%0d expected 1/0", n_rd - r0, proto_err - p0);
    else n_pass++;
    lock_req = 1'b0;
    repeat (10) step();
    n_checks++;
    if (busy !== 1'b0 || mutex_val !== REL_WORD)
      $display("FAIL stall_release: got busy=%b mutex=%h expected 0/%h", busy, mutex_val, REL_WORD);
    else n_pass++;
    stall_min = 0;
    stall_max = 0;
    lat_min   = 1;
    lat_max   = 1;
  endtask

  task automatic test_drop_in_wait_rd();
    int r0, w0;
    logic ok, saw_grant;
    mutex_val = 32'h0;
    lat_min = 3;
    lat_max = 3;
    r0 = n_rd;
    w0 = wr_log_data.size();
    lock_req = 1'b1;
    ok = 1'b0;
    saw_grant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (n_rd > r0) begin
        ok = 1'b1;
        break;
      end
    end
    lock_req = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL drop_read_issued: got 0 reads expected 1");
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lock_grant) saw_grant = 1'b1;
    end
    n_checks++;
    if (saw_grant !== 1'b0) $display("FAIL drop_no_grant: got grant=1 expected 0");
    else n_pass++;
    n_checks++;
    if (wr_log_data.size() != w0 + 2 || wr_log_data[w0 + 1] !== REL_WORD || mutex_val !== REL_WORD)
      $display("FAIL drop_release: got %0d writes mutex=%h expected 2 and %h",
               wr_log_data.size() - w0, mutex_val, REL_WORD);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL drop_idle: got busy=%b expected 0", busy);
    else n_pass++;
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_reset_in_held();
    int w0;
    logic ok;
    mutex_val = 32'h0;
    lock_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lock_grant) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL held_before_reset: got grant=0 expected 1");
    else n_pass++;
    w0 = wr_log_data.size();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({lock_grant, busy, m_chipselect, m_read, m_write, retry_count, m_writedata} !== 45'h0)
      $display("FAIL async_reset: got grant=%b busy=%b write=%b wdata=%h expected all 0",
               lock_grant, busy, m_write, m_writedata);
    else n_pass++;
    lock_req = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (5) step();
    n_checks++;
    if (wr_log_data.size() != w0 || mutex_val !== LOCK_WORD)
      $display("FAIL reset_no_release: got %0d writes mutex=%h expected 0 and %h",
               wr_log_data.size() - w0, mutex_val, LOCK_WORD);
    else n_pass++;
    n_checks++;
    if ({lock_grant, busy} !== 2'b00)
      $display("FAIL reset_idle: got grant=%b busy=%b expected 0/0", lock_grant, busy);
    else n_pass++;
    mutex_val = 32'h0;
  endtask

  task automatic test_random();
    int   ref_retry, n_grants, p0;
    logic was_idle, pend_fail, pend_ok, grant_prev, ok;
    logic [33:0] exp_rel;
    ref_retry  = 0;
    n_grants   = 0;
    was_idle   = 1'b1;
    pend_fail  = 1'b0;
    pend_ok    = 1'b0;
    grant_prev = 1'b0;
    p0         = proto_err;
    stall_min  = 0;
    stall_max  = 3;
    lat_min    = 1;
    lat_max    = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29, 0) == 0) lock_req = ~lock_req;
      // Software agent with owner 0x0002: it grabs a free mutex or frees its own.
      if (mutex_val[15:0] == 16'h0 && $urandom_range(39, 0) == 0)
        mutex_val = {16'h0002, 16'($urandom_range(65535, 1))};
      else if (mutex_val[31:16] == 16'h0002 && mutex_val[15:0] != 16'h0 && $urandom_range(24, 0) == 0)
        mutex_val = 32'h0002_0000;
      step();
      if (pend_fail) ref_retry = (ref_retry == 255) ? 255 : ref_retry + 1;
      if (was_idle && busy) ref_retry = 0;
      n_checks++;
      if (retry_count !== 8'(ref_retry))
        $display("FAIL rand_retry: cycle %0d got %0d expected %0d", i, retry_count, ref_retry);
      else n_pass++;
      n_checks++;
      if (lock_grant && (mutex_val !== LOCK_WORD || lock_req !== 1'b1))
        $display("FAIL rand_grant_valid: cycle %0d got mutex=%h req=%b expected %h/1", i, mutex_val, lock_req, LOCK_WORD);
      else n_pass++;
      n_checks++;
      if (lock_grant && busy) $display("FAIL rand_busy: cycle %0d got busy=1 with grant expected 0", i);
      else n_pass++;
`ifndef MUTEX_TIMEOUT_EN
      n_checks++;
      if (lock_fail !== 1'b0) $display("FAIL rand_lock_fail: cycle %0d got 1 expected 0", i);
      else n_pass++;
`endif
      if (pend_ok) begin
        exp_rel = lock_req ? {1'b1, 1'b0, 32'h0} : {1'b0, 1'b1, REL_WORD};
        n_checks++;
        if ({lock_grant, m_write, m_writedata} !== exp_rel)
          $display("FAIL rand_after_success: cycle %0d got %h expected %h", i,
                   {lock_grant, m_write, m_writedata}, exp_rel);
        else n_pass++;
      end
      pend_fail = m_readdatavalid && (m_readdata !== LOCK_WORD);
      pend_ok   = m_readdatavalid && (m_readdata === LOCK_WORD);
      was_idle  = !busy && !lock_grant;
      if (lock_grant && !grant_prev) n_grants++;
      grant_prev = lock_grant;
    end
    lock_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy && !lock_grant) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || (mutex_val[31:16] == 16'h0001 && mutex_val[15:0] != 16'h0))
      $display("FAIL rand_final_release: got idle=%b mutex=%h expected 1 and not held", ok, mutex_val);
    else n_pass++;
    n_checks++;
    if (proto_err != p0) $display("FAIL rand_protocol: got %0d errors expected 0", proto_err - p0);
    else n_pass++;
    n_checks++;
    if (n_grants == 0) $display("FAIL rand_grants: got 0 grants expected >0");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_acquire();
    test_contended();
    test_waitrequest();
    test_drop_in_wait_rd();
    test_reset_in_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
